// File: rtl/timestamp_pkg.sv
// Shared timestamp types for the port timestamp exchange.
//   WIDTH        : timestamp width in bits
//   timestamp_t  : WIDTH-bit unsigned timestamp
//   sync_state_t : per-port resync state (INIT waits for a first sample, RUN free-runs)
//   HOLDOFF_W    : width of the post-sample holdoff counter (holdoff range 0..15)
//   sat_inc16    : 16-bit saturating increment used for sample counters
`timescale 1ns/1ps
package timestamp_pkg;

  localparam int WIDTH     = 53;
  localparam int HOLDOFF_W = 4;

  typedef logic [WIDTH-1:0] timestamp_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } sync_state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/ts_step_clamp.sv
// Forward-only step limiter for the local timestamp.
// Given the local value L, the offered global value G and the largest
// allowed forward jump, returns the base the counter should move to
// (before the per-cycle increment is added).
//   local_ts  : current local timestamp L
//   global_ts : offered global timestamp G
//   max_step  : largest permitted forward jump
//   next_base : L when G<=L, G when 0<G-L<=max_step, L+max_step otherwise
//   ahead     : G > L (the sample would move the counter)
//   clamped   : G-L exceeded max_step and the jump was limited
`timescale 1ns/1ps
module ts_step_clamp #(
  parameter int WIDTH = timestamp_pkg::WIDTH
) (
  input  logic [WIDTH-1:0] local_ts,
  input  logic [WIDTH-1:0] global_ts,
  input  logic [WIDTH-1:0] max_step,
  output logic [WIDTH-1:0] next_base,
  output logic             ahead,
  output logic             clamped
);

  logic [WIDTH-1:0] diff;

  // Plain unsigned compare: wrap of a 53-bit counter is never reached in service.
  assign ahead   = global_ts > local_ts;
  assign diff    = global_ts - local_ts;
  assign clamped = ahead && (diff > max_step);

  always_comb begin
    if (!ahead) begin
      next_base = local_ts;
    end else if (clamped) begin
      next_base = local_ts + max_step;
    end else begin
      next_base = global_ts;
    end
  end

endmodule

// File: rtl/local_timestamp_sync.sv
// Per-port local timestamp counter, resynchronised forward to the
// registered global maximum timestamp.
//   clock            : block clock
//   reset_n          : asynchronous active-low reset
//   enable           : port enable; low freezes the counter and returns to INIT
//   global_valid     : global_timestamp valid this cycle
//   global_timestamp : registered global maximum timestamp
//   global_ready     : a sample is accepted this cycle if global_valid is high
//   timestamp_local  : local timestamp counter (sampled by the max block)
//   adjust_pulse     : one-cycle pulse, the counter was moved by a sample
//   jump_error       : one-cycle pulse, a forward jump was clamped to MAX_STEP
//   sync_count       : accepted samples, saturating at 16'hFFFF
`timescale 1ns/1ps
module local_timestamp_sync
  import timestamp_pkg::*;
#(
  parameter int               WIDTH    = timestamp_pkg::WIDTH,
  parameter logic [WIDTH-1:0] INC      = 1,
  parameter logic [WIDTH-1:0] MAX_STEP = 1024,
  parameter int unsigned      HOLDOFF  = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             global_valid,
  input  logic [WIDTH-1:0] global_timestamp,
  output logic             global_ready,
  output logic [WIDTH-1:0] timestamp_local,
  output logic             adjust_pulse,
  output logic             jump_error,
  output logic [15:0]      sync_count
);

  localparam logic [HOLDOFF_W-1:0] HOLDOFF_LOAD = HOLDOFF_W'(HOLDOFF);

  sync_state_t          state;
  logic [HOLDOFF_W-1:0] holdoff;
  logic [HOLDOFF_W-1:0] holdoff_next;
  logic                 ready_q;
  logic                 accept;
  logic [WIDTH-1:0]     next_base;
  logic                 ahead;
  logic                 clamped;

  ts_step_clamp #(.WIDTH(WIDTH)) u_step_clamp (
    .local_ts  (timestamp_local),
    .global_ts (global_timestamp),
    .max_step  (MAX_STEP),
    .next_base (next_base),
    .ahead     (ahead),
    .clamped   (clamped)
  );

  // ready_q is the registered "holdoff expired" flag and is cleared by reset,
  // so global_ready is low during reset; enable gates it directly so that a
  // disabled port never advertises readiness.
  assign global_ready = enable && ready_q;
  assign accept       = global_valid && global_ready;

  // NOTE: every signal driven in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    holdoff_next = holdoff;
    if (accept) begin
      holdoff_next = HOLDOFF_LOAD;
    end else if (holdoff != '0) begin
      holdoff_next = holdoff - 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state           <= INIT;
      holdoff         <= '0;
      ready_q         <= 1'b0;
      timestamp_local <= '0;
      adjust_pulse    <= 1'b0;
      jump_error      <= 1'b0;
      sync_count      <= '0;
    end else begin
      holdoff      <= holdoff_next;
      ready_q      <= (holdoff_next == '0);
      adjust_pulse <= 1'b0;
      jump_error   <= 1'b0;

      if (!enable) begin
        // Counter holds its value; the next enabled sample reloads it.
        state <= INIT;
      end else begin
        unique case (state)
          INIT: begin
            if (accept) begin
              timestamp_local <= global_timestamp + INC;
              adjust_pulse    <= 1'b1;
              sync_count      <= sat_inc16(sync_count);
              state           <= RUN;
            end
          end
          RUN: begin
            if (accept) begin
              // Stale samples (G<=L) give next_base==L: plain increment.
              timestamp_local <= next_base + INC;
              adjust_pulse    <= ahead;
              jump_error      <= clamped;
              sync_count      <= sat_inc16(sync_count);
            end else begin
              timestamp_local <= timestamp_local + INC;
            end
          end
          default: state <= INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_local_timestamp_sync.sv
// Directed self-checking bench for local_timestamp_sync
// (WIDTH=53, INC=1, MAX_STEP=1024, HOLDOFF=4).
`timescale 1ns/1ps
module tb_local_timestamp_sync;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        global_valid;
  logic [52:0] global_timestamp;
  logic        global_ready;
  logic [52:0] timestamp_local;
  logic        adjust_pulse;
  logic        jump_error;
  logic [15:0] sync_count;

  int checks = 0;
  int errors = 0;
  int exp_sync = 0;

  always #5 clock = ~clock;

  local_timestamp_sync #(
    .WIDTH    (53),
    .INC      (53'd1),
    .MAX_STEP (53'd1024),
    .HOLDOFF  (4)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .enable           (enable),
    .global_valid     (global_valid),
    .global_timestamp (global_timestamp),
    .global_ready     (global_ready),
    .timestamp_local  (timestamp_local),
    .adjust_pulse     (adjust_pulse),
    .jump_error       (jump_error),
    .sync_count       (sync_count)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one rising edge and settle 1ns past it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Offer one sample for a single edge; the caller has checked global_ready.
  task automatic offer(input logic [52:0] g);
    global_valid     = 1'b1;
    global_timestamp = g;
    step();
    global_valid     = 1'b0;
    exp_sync++;
  endtask

  // Disable, re-enable and reload so that the counter sits at `target`
  // in RUN with global_ready high (target-5 loads to target-4, +4 cycles).
  task automatic set_base(input string tag, input logic [52:0] target);
    logic [52:0] held;
    held   = timestamp_local;
    enable = 1'b0;
    #1;
    check({tag, "_dis_ready"}, 64'(global_ready), 64'd0);
    step();
    check({tag, "_dis_hold"}, 64'(timestamp_local), 64'(held));
    repeat (3) step();
    enable = 1'b1;
    #1;
    check({tag, "_init_ready"}, 64'(global_ready), 64'd1);
    offer(target - 53'd5);
    repeat (4) step();
    check({tag, "_base"}, 64'(timestamp_local), 64'(target));
    check({tag, "_base_ready"}, 64'(global_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n          = 1'b0;
    enable           = 1'b0;
    global_valid     = 1'b0;
    global_timestamp = '0;

    // Reset state.
    #12;
    check("rst_ts", 64'(timestamp_local), 64'd0);
    check("rst_ready", 64'(global_ready), 64'd0);
    check("rst_sync", 64'(sync_count), 64'd0);
    reset_n = 1'b1;
    enable  = 1'b1;
    step();
    check("init_ts", 64'(timestamp_local), 64'd0);
    check("init_ready", 64'(global_ready), 64'd1);
    step();
    check("init_no_inc", 64'(timestamp_local), 64'd0);

    // First sync G=1000 and holdoff window, with an ignored sample inside it.
    offer(53'd1000);
    check("first_ts", 64'(timestamp_local), 64'd1001);
    check("first_adj", 64'(adjust_pulse), 64'd1);
    check("first_jerr", 64'(jump_error), 64'd0);
    check("first_sync", 64'(sync_count), 64'(exp_sync));
    check("hold0_ready", 64'(global_ready), 64'd0);
    global_valid     = 1'b1;
    global_timestamp = 53'd50000;
    step();
    check("hold1_ts", 64'(timestamp_local), 64'd1002);
    check("hold1_adj", 64'(adjust_pulse), 64'd0);
    check("hold1_ready", 64'(global_ready), 64'd0);
    check("hold1_sync", 64'(sync_count), 64'(exp_sync));
    step();
    global_valid = 1'b0;
    check("hold2_ts", 64'(timestamp_local), 64'd1003);
    check("hold2_ready", 64'(global_ready), 64'd0);
    check("hold2_sync", 64'(sync_count), 64'(exp_sync));
    step();
    check("hold3_ready", 64'(global_ready), 64'd0);
    step();
    check("hold_end_ts", 64'(timestamp_local), 64'd1005);
    check("hold_end_ready", 64'(global_ready), 64'd1);

    // Small jump L=2000, G=2500.
    set_base("small", 53'd2000);
    offer(53'd2500);
    check("small_ts", 64'(timestamp_local), 64'd2501);
    check("small_adj", 64'(adjust_pulse), 64'd1);
    check("small_jerr", 64'(jump_error), 64'd0);
    check("small_sync", 64'(sync_count), 64'(exp_sync));

    // Clamped jump L=2000, G=5000 -> 2000+1024+1.
    set_base("clamp", 53'd2000);
    offer(53'd5000);
    check("clamp_ts", 64'(timestamp_local), 64'd3025);
    check("clamp_adj", 64'(adjust_pulse), 64'd1);
    check("clamp_jerr", 64'(jump_error), 64'd1);
    step();
    check("clamp_pulse_end", 64'({adjust_pulse, jump_error}), 64'd0);
    check("clamp_next_ts", 64'(timestamp_local), 64'd3026);

    // Exactly MAX_STEP ahead: no clamp.
    set_base("edge", 53'd2000);
    offer(53'd3024);
    check("edge_ts", 64'(timestamp_local), 64'd3025);
    check("edge_adj", 64'(adjust_pulse), 64'd1);
    check("edge_jerr", 64'(jump_error), 64'd0);

    // MAX_STEP+1 ahead: clamp.
    set_base("over", 53'd2000);
    offer(53'd3025);
    check("over_ts", 64'(timestamp_local), 64'd3025);
    check("over_jerr", 64'(jump_error), 64'd1);

    // Stale sample L=2000, G=1500.
    set_base("stale", 53'd2000);
    offer(53'd1500);
    check("stale_ts", 64'(timestamp_local), 64'd2001);
    check("stale_adj", 64'(adjust_pulse), 64'd0);
    check("stale_jerr", 64'(jump_error), 64'd0);
    check("stale_sync", 64'(sync_count), 64'(exp_sync));

    // Equal sample G==L counts but does not adjust.
    set_base("equal", 53'd2000);
    offer(53'd2000);
    check("equal_ts", 64'(timestamp_local), 64'd2001);
    check("equal_adj", 64'(adjust_pulse), 64'd0);

    // Enable drop at L=3000, then re-enable and reload G=10 unconditionally.
    set_base("en", 53'd3000);
    enable = 1'b0;
    step();
    check("en_hold_ts", 64'(timestamp_local), 64'd3000);
    check("en_hold_ready", 64'(global_ready), 64'd0);
    step();
    check("en_hold2_ts", 64'(timestamp_local), 64'd3000);
    enable = 1'b1;
    #1;
    check("reen_ready", 64'(global_ready), 64'd1);
    offer(53'd10);
    check("reen_ts", 64'(timestamp_local), 64'd11);
    check("reen_adj", 64'(adjust_pulse), 64'd1);
    check("reen_jerr", 64'(jump_error), 64'd0);
    check("reen_sync", 64'(sync_count), 64'(exp_sync));
    step();
    check("reen_run_ts", 64'(timestamp_local), 64'd12);

    // Asynchronous reset mid-count, observed before the next edge.
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("arst_ts", 64'(timestamp_local), 64'd0);
    check("arst_sync", 64'(sync_count), 64'd0);
    check("arst_ready", 64'(global_ready), 64'd0);
    check("arst_pulses", 64'({adjust_pulse, jump_error}), 64'd0);
    #2;
    reset_n = 1'b1;
    step();
    check("post_rst_ts", 64'(timestamp_local), 64'd0);
    check("post_rst_ready", 64'(global_ready), 64'd1);
    step();
    check("post_rst_init", 64'(timestamp_local), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
